// File: rtl/vedic_mac_16.sv
// Streaming 16x16 unsigned multiply-accumulate around a Vedic multiplier.
// Ports: in_* operand handshake, acc_clr discard, out_* frame result handshake.

module ved_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c1;
  assign p[3] = (a[1] & b[1]) & c1;
endmodule

module ved_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  logic [4:0] mid;
  ved_2x2 u0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  ved_2x2 u1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  ved_2x2 u2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  ved_2x2 u3 (.a(a[3:2]), .b(b[3:2]), .p(q3));
  // Vertical-and-crosswise: outer terms abut, cross terms add mid-way.
  assign mid = {1'b0, q1} + {1'b0, q2};
  assign p   = {q3, q0} + {1'b0, mid, 2'b0};
endmodule

module ved_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;
  logic [8:0] mid;
  ved_4x4 u0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  ved_4x4 u1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  ved_4x4 u2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  ved_4x4 u3 (.a(a[7:4]), .b(b[7:4]), .p(q3));
  assign mid = {1'b0, q1} + {1'b0, q2};
  assign p   = {q3, q0} + {3'b0, mid, 4'b0};
endmodule

module ved_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] q0, q1, q2, q3;
  logic [16:0] mid;
  ved_8x8 u0 (.a(a[7:0]),  .b(b[7:0]),  .p(q0));
  ved_8x8 u1 (.a(a[15:8]), .b(b[7:0]),  .p(q1));
  ved_8x8 u2 (.a(a[7:0]),  .b(b[15:8]), .p(q2));
  ved_8x8 u3 (.a(a[15:8]), .b(b[15:8]), .p(q3));
  assign mid = {1'b0, q1} + {1'b0, q2};
  assign p   = {q3, q0} + {7'b0, mid, 8'b0};
endmodule

module vedic_mac_16 #(
  parameter int ACC_W     = 40,
  parameter int FRAME_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_count,
  output logic             out_ovf
);
  localparam logic [7:0] FL = 8'(FRAME_LEN);

  logic             s1_valid_q, s1_valid_d;
  logic [15:0]      s1_a_q, s1_a_d;
  logic [15:0]      s1_b_q, s1_b_d;
  logic             s1_last_q, s1_last_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_prod_q, s2_prod_d;
  logic             s2_last_q, s2_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [7:0]       out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             adv, accept, close, f_ovf;
  logic [31:0]      prod;
  logic [ACC_W:0]   sum_w;
  logic [7:0]       cnt_next;

  ved_16x16 u_mul (.a(s1_a_q), .b(s1_b_q), .p(prod));

  // A result stuck at the output freezes every stage, including input.
  assign adv      = ~(out_valid_q & ~out_ready);
  assign accept   = in_valid & adv;
  assign sum_w    = {1'b0, acc_q}
                  + {{(ACC_W-31){1'b0}}, s2_prod_q};
  assign f_ovf    = sum_w[ACC_W] | ovf_q;
  assign cnt_next = count_q + 8'd1;
  // acc_clr kills the product in s2, so it can never close a frame.
  assign close    = s2_valid_q & ~acc_clr
                  & (s2_last_q | (cnt_next == FL));

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_last_d   = s2_last_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_a_d    = in_a;
        s1_b_d    = in_b;
        s1_last_d = in_last;
      end
      s2_valid_d  = s1_valid_q;
      s2_prod_d   = prod;
      s2_last_d   = s1_last_q;
      // adv with a pending result implies out_ready, so it drains here.
      out_valid_d = close;
      if (close) begin
        out_acc_d   = sum_w[ACC_W-1:0];
        out_count_d = cnt_next;
        out_ovf_d   = f_ovf;
      end
      if (acc_clr || close) begin
        acc_d   = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end else if (s2_valid_q) begin
        acc_d   = sum_w[ACC_W-1:0];
        count_d = cnt_next;
        ovf_d   = f_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_vedic_mac_16.sv
// Bench for vedic_mac_16: four parameterisations, directed and random
// traffic, results scored against a frame-sum model.

module tb_vedic_mac_16;
  typedef struct {
    logic [39:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  localparam int FLS [4] = '{4, 8, 1, 2};
  localparam int WS  [4] = '{40, 40, 40, 32};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv [4];
  logic        ir [4];
  logic [15:0] ia [4];
  logic [15:0] ib [4];
  logic        lst [4];
  logic        clr [4];
  logic        ov [4];
  logic        ord [4];
  logic [7:0]  ocnt [4];
  logic        oovf [4];
  logic [39:0] oacc [3];
  logic [31:0] oacc32;

  int nvec = 0;
  int nerr = 0;

  longint unsigned msum [4];
  int              mcnt [4];
  res_t            expq [4][$];

  always #5 clk = ~clk;

  vedic_mac_16 #(.ACC_W(40), .FRAME_LEN(4)) u_f4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0]), .in_b(ib[0]), .in_last(lst[0]), .acc_clr(clr[0]),
    .out_valid(ov[0]), .out_ready(ord[0]), .out_acc(oacc[0]),
    .out_count(ocnt[0]), .out_ovf(oovf[0]));

  vedic_mac_16 #(.ACC_W(40), .FRAME_LEN(8)) u_f8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1]), .in_b(ib[1]), .in_last(lst[1]), .acc_clr(clr[1]),
    .out_valid(ov[1]), .out_ready(ord[1]), .out_acc(oacc[1]),
    .out_count(ocnt[1]), .out_ovf(oovf[1]));

  vedic_mac_16 #(.ACC_W(40), .FRAME_LEN(1)) u_f1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2]), .in_b(ib[2]), .in_last(lst[2]), .acc_clr(clr[2]),
    .out_valid(ov[2]), .out_ready(ord[2]), .out_acc(oacc[2]),
    .out_count(ocnt[2]), .out_ovf(oovf[2]));

  vedic_mac_16 #(.ACC_W(32), .FRAME_LEN(2)) u_o32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_a(ia[3]), .in_b(ib[3]), .in_last(lst[3]), .acc_clr(clr[3]),
    .out_valid(ov[3]), .out_ready(ord[3]), .out_acc(oacc32),
    .out_count(ocnt[3]), .out_ovf(oovf[3]));

  function automatic logic [39:0] gacc(input int k);
    if (k == 3) return {8'h0, oacc32};
    return oacc[k];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    nvec++;
    assert (obs === exp_v) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Model: exact frame sum; result wraps at W bits, ovf iff sum >= 2^W.
  task automatic model_accept(input int k, input logic [15:0] a,
                              input logic [15:0] b, input logic l);
    res_t r;
    msum[k] += longint'(a) * longint'(b);
    mcnt[k]++;
    if (l || mcnt[k] == FLS[k]) begin
      r.acc = 40'(msum[k] & ((64'd1 << WS[k]) - 64'd1));
      r.cnt = 8'(mcnt[k]);
      r.ovf = (msum[k] >> WS[k]) != 0;
      expq[k].push_back(r);
      msum[k] = 0;
      mcnt[k] = 0;
    end
  endtask

  task automatic feed(input int k, input logic [15:0] a,
                      input logic [15:0] b, input logic l);
    int   n;
    logic took;
    n = 0;
    iv[k] = 1'b1; ia[k] = a; ib[k] = b; lst[k] = l;
    do begin
      took = ir[k];
      @(posedge clk); #1;
      n++;
    end while (!took && n < 50);
    chk("feed_accept", 64'(took), 1);
    iv[k] = 1'b0;
    lst[k] = 1'b0;
  endtask

  task automatic wait_out(input int k);
    int n;
    n = 0;
    while (!ov[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_timeout", 64'(ov[k]), 1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    res_t e;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 0; ia[k] = 0; ib[k] = 0; lst[k] = 0;
      clr[k] = 0; ord[k] = 1; msum[k] = 0; mcnt[k] = 0;
    end

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          for (int k = 0; k < 4; k++) begin
            if (iv[k] && ir[k]) model_accept(k, ia[k], ib[k], lst[k]);
            if (ov[k] && ord[k]) begin
              chk("result_expected", 64'(expq[k].size() != 0), 1);
              if (expq[k].size() != 0) begin
                e = expq[k].pop_front();
                chk("sb_acc", 64'(gacc(k)), 64'(e.acc));
                chk("sb_cnt", 64'(ocnt[k]), 64'(e.cnt));
                chk("sb_ovf", 64'(oovf[k]), 64'(e.ovf));
              end
            end
          end
        end
      end
    join_none

    // Reset state
    #12;
    chk("rst_out_valid", 64'(ov[0]), 0);
    chk("rst_out_acc", 64'(gacc(0)), 0);
    chk("rst_out_count", 64'(ocnt[0]), 0);
    chk("rst_out_ovf", 64'(oovf[0]), 0);
    chk("rst_in_ready", 64'(ir[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Four-product frame with latency check
    feed(0, 3, 5, 0);
    feed(0, 7, 11, 0);
    feed(0, 65535, 65535, 0);
    feed(0, 0, 9, 0);
    chk("lat_e3", 64'(ov[0]), 0);
    step(1);
    chk("lat_e4", 64'(ov[0]), 0);
    step(1);
    chk("lat_e5", 64'(ov[0]), 1);
    chk("f4_acc", 64'(gacc(0)), 64'd4294836317);
    chk("f4_cnt", 64'(ocnt[0]), 4);
    chk("f4_ovf", 64'(oovf[0]), 0);
    step(1);
    chk("one_cycle", 64'(ov[0]), 0);

    // Early close on first product, then full frame
    feed(1, 2, 3, 1);
    wait_out(1);
    chk("last1_acc", 64'(gacc(1)), 6);
    chk("last1_cnt", 64'(ocnt[1]), 1);
    step(1);
    for (int i = 0; i < 8; i++) feed(1, 4, 4, 0);
    wait_out(1);
    chk("f8_acc", 64'(gacc(1)), 128);
    chk("f8_cnt", 64'(ocnt[1]), 8);
    step(2);

    // Backpressure with FRAME_LEN=1
    ord[2] = 1'b0;
    feed(2, 1000, 1000, 0);
    feed(2, 2, 2, 0);
    wait_out(2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_acc", 64'(gacc(2)), 1000000);
      chk("bp_in_ready", 64'(ir[2]), 0);
      step(1);
    end
    ord[2] = 1'b1;
    step(1);
    chk("bp_next_valid", 64'(ov[2]), 1);
    chk("bp_next_acc", 64'(gacc(2)), 4);
    step(1);
    chk("bp_no_dup", 64'(ov[2]), 0);

    // Overflow with ACC_W=32
    feed(3, 65535, 65535, 0);
    feed(3, 65535, 65535, 0);
    wait_out(3);
    chk("ovf_acc", 64'(gacc(3)), 64'd4294705154);
    chk("ovf_flag", 64'(oovf[3]), 1);
    step(1);
    feed(3, 1, 1, 0);
    feed(3, 1, 1, 0);
    wait_out(3);
    chk("ovf_next_acc", 64'(gacc(3)), 2);
    chk("ovf_next_flag", 64'(oovf[3]), 0);
    step(2);

    // acc_clr on the edge the second product sits in s2
    feed(0, 10, 10, 0);
    feed(0, 10, 10, 0);
    step(1);
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    msum[0] = 0;
    mcnt[0] = 0;
    for (int i = 0; i < 4; i++) feed(0, 1, 1, 0);
    wait_out(0);
    chk("clr_acc", 64'(gacc(0)), 4);
    chk("clr_cnt", 64'(ocnt[0]), 4);
    step(2);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int k = 1; k < 4; k += 2) begin
        iv[k]  = $urandom_range(0, 3) != 0;
        ia[k]  = ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom);
        ib[k]  = ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom);
        lst[k] = $urandom_range(0, 5) == 0;
        ord[k] = $urandom_range(0, 3) != 0;
      end
      step(1);
    end
    for (int k = 1; k < 4; k += 2) begin
      iv[k] = 0;
      ord[k] = 1;
    end
    feed(1, 1, 1, 1);
    feed(3, 1, 1, 1);
    step(8);
    chk("rand_drain_f8", 64'(expq[1].size()), 0);
    chk("rand_drain_o32", 64'(expq[3].size()), 0);

    // Asynchronous reset mid-frame with a result pending
    ord[2] = 1'b0;
    feed(2, 5, 5, 0);
    feed(2, 6, 6, 0);
    wait_out(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov[2]), 0);
    chk("arst_acc", 64'(gacc(2)), 0);
    chk("arst_cnt", 64'(ocnt[2]), 0);
    chk("arst_ovf", 64'(oovf[2]), 0);
    for (int k = 0; k < 4; k++) begin
      msum[k] = 0;
      mcnt[k] = 0;
      expq[k].delete();
    end
    ord[2] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("arst_in_ready", 64'(ir[2]), 1);
    feed(2, 3, 3, 0);
    wait_out(2);
    chk("arst_fresh_acc", 64'(gacc(2)), 9);
    chk("arst_fresh_cnt", 64'(ocnt[2]), 1);
    step(3);
    chk("final_drain", 64'(expq[2].size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vedic_mac_16.md
Name: vedic_mac_16

Overview:
Streaming multiply-accumulate stage built around the existing ved_16x16 combinational multiplier, instantiated once inside this block. Accepts unsigned 16-bit operand pairs over a valid/ready handshake. Registers the operands and the 32-bit product, then accumulates products into frames. Emits one accumulated result per frame over a valid/ready output handshake; this is the sequential wrapper that consumes every product the multiplier produces.

Parameters:
ACC_W, 40, accumulator/result width in bits; legal range 32..48.
FRAME_LEN, 8, products per frame when in_last is not asserted; legal range 1..255.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept an operand pair this cycle.
in_a  input  16  unsigned multiplicand.
in_b  input  16  unsigned multiplier.
in_last  input  1  closes the frame early with this pair.
acc_clr  input  1  synchronous discard of the partial frame.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_acc  output  ACC_W  frame sum of products.
out_count  output  8  number of products in the frame.
out_ovf  output  1  frame sum wrapped past ACC_W bits.

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid, s2_valid, out_valid, out_ovf = 0.
  - acc, count, out_acc, out_count = 0.
  - in_ready = 1 once out_valid = 0.
- Advance enable: adv = ~(out_valid & ~out_ready).
  - When adv = 0 the whole pipeline freezes: s1, s2, acc, count and out_* all hold.
  - in_ready = adv, combinational.
  - Accept occurs on the edge where in_valid & in_ready = 1.
- Stage 1 (on adv): s1_valid <= accepted; s1_a, s1_b, s1_last <= inputs when accepted. Registers hold their value when nothing is accepted; only s1_valid drops.
- Multiply: ved_16x16 is driven from s1_a/s1_b. Purely combinational, no multi-cycle path.
- Stage 2 (on adv): s2_valid <= s1_valid; s2_prod <= the 32-bit product; s2_last <= s1_last.
- Accumulate (on adv, s2_valid = 1):
  - sum = acc + zero-extended s2_prod, truncated to ACC_W bits.
  - carry-out of that addition, or ovf already set → frame ovf is 1.
  - cnt_next = count + 1.
  - Frame closes when s2_last = 1 or cnt_next = FRAME_LEN.
    - On close: out_acc <= sum; out_count <= cnt_next; out_ovf <= frame ovf; out_valid <= 1; acc, count, ovf <= 0.
    - Otherwise: acc <= sum; count <= cnt_next; ovf <= frame ovf.
- Output handshake:
  - out_valid clears on the edge where out_ready = 1, unless a new close happens on that same edge. In that case out_valid stays 1 and out_* load the new frame.
  - out_* are stable while out_valid = 1 and out_ready = 0.
- Latency: pair accepted at edge E0 → s2 at E1 → accumulated at E2. A closing pair gives out_valid = 1 in the cycle after E2, i.e. 3 cycles total with no stall.
- Throughput: one pair per cycle with no stall.
- acc_clr (sampled only when adv = 1):
  - acc, count, ovf <= 0.
  - The product in s2 on that edge is discarded; no close fires even if it would have.
  - s1 contents move to s2 normally.
  - out_* are not affected.
- Boundaries:
  - FRAME_LEN = 1: every product closes a frame.
  - in_last on a frame's first product: out_count = 1.
  - The pipeline holds with no data loss while frozen.
- Reset mid-frame: all in-flight pairs and the partial sum are lost; there is no output for the interrupted frame.

Test Plan:
- FRAME_LEN=4, ACC_W=40, out_ready=1: pairs (3,5), (7,11), (65535,65535), (0,9) on consecutive cycles → out_acc = 4294836317, out_count = 4, out_ovf = 0. out_valid is high for exactly one cycle, 3 cycles after the 4th accept.
- FRAME_LEN=8: pair (2,3) with in_last=1 → out_acc = 6, out_count = 1. Then (4,4) ×8 → out_acc = 128, out_count = 8.
- Backpressure: FRAME_LEN=1, out_ready=0 for 5 cycles after the first result (1000,1000):
  - out_acc holds 1000000.
  - in_ready = 0 throughout; the pipeline holds.
  - When out_ready rises, queued pair (2,2) yields 4 with no loss or duplication.
- Overflow: ACC_W=32, FRAME_LEN=2, pairs (65535,65535) ×2 → out_acc = 4294705154, out_ovf = 1. The next frame (1,1) ×2 → 2, out_ovf = 0.
- acc_clr: FRAME_LEN=4. Feed (10,10), (10,10); pulse acc_clr on the edge the second product is in s2. Then feed (1,1) ×4 → out_acc = 4, out_count = 4.
- Reset: assert rst_n=0 asynchronously mid-frame with out_valid=1 → out_valid, out_acc, out_count, out_ovf = 0 immediately. After release, in_ready = 1 and a fresh frame accumulates from 0.
